abr_slice_serializer: RTL

Streams a buffered `InW`-bit word out as a sequence of `OutW`-bit slices over a valid/ready handshake. It sits directly upstream of, and instantiates, the generic slicer primitive, and owns the slice-index counter that drives the slicer's select. It carries message framing: a per-word slice count and a last-word flag. It feeds the byte- or word-oriented consumers of the hash and sampler datapaths.

---
 rtl/abr_slice_ser_pkg.sv | 13 +
 rtl/abr_prim_slicer.sv | 21 ++
 rtl/abr_slice_serializer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/abr_slice_ser_pkg.sv
// Shared types and helpers for the slice serializer.
package abr_slice_ser_pkg;

  typedef enum logic {
    SerIdle = 1'b0,
    SerSend = 1'b1
  } slice_ser_state_e;

  function automatic int unsigned calc_num_slices(int unsigned in_w, int unsigned out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/abr_prim_slicer.sv
// Generic slicer: picks OutW-bit slice sel_i of data_i; slices past the top of
// the word (and the top fractional slice) are zero-filled.
module abr_prim_slicer #(
  parameter int unsigned InW    = 64,
  parameter int unsigned OutW   = 8,
  parameter int unsigned IndexW = 4
) (
  input  logic [IndexW-1:0] sel_i,
  input  logic [InW-1:0]    data_i,
  output logic [OutW-1:0]   data_o
);

  localparam int unsigned NumLanes = 2**IndexW;
  localparam int unsigned PadW     = NumLanes * OutW;

  logic [NumLanes-1:0][OutW-1:0] lanes;

  assign lanes  = PadW'(data_i);
  assign data_o = lanes[sel_i];

endmodule

// File: rtl/abr_slice_serializer.sv
// Serializes an InW-bit word into OutW-bit slices with per-word slice count and
// last-word framing. Define ABR_SLICE_SER_ZEROIZE_EN to add the zeroize_i clear.
module abr_slice_serializer
  import abr_slice_ser_pkg::*;
#(
  parameter int unsigned InW    = 64,
  parameter int unsigned OutW   = 8,
  parameter int unsigned IndexW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [InW-1:0]    in_data_i,
  input  logic [IndexW:0]   in_nslices_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OutW-1:0]   out_data_o,
  output logic              out_last_o,
`ifdef ABR_SLICE_SER_ZEROIZE_EN
  input  logic              zeroize_i,
`endif
  output logic              busy_o
);

  localparam int unsigned   NumSlices = calc_num_slices(InW, OutW);
  localparam int unsigned   CntW      = IndexW + 1;
  localparam logic [IndexW:0]   NumSlicesC = CntW'(NumSlices);
  localparam logic [IndexW:0]   CntOne     = CntW'(1);
  localparam logic [IndexW-1:0] IdxOne     = IndexW'(1);

  if (InW > OutW * (2**IndexW)) begin : g_bad_params
    $error("abr_slice_serializer: InW must not exceed OutW*2**IndexW");
  end

  slice_ser_state_e  state_q, state_d;
  logic [InW-1:0]    data_q, data_d;
  logic [IndexW-1:0] idx_q, idx_d;
  logic [IndexW:0]   n_q, n_d;
  logic              last_q, last_d;

  logic [IndexW:0]   n_clamped;
  logic              is_final;
  logic              load;

  assign n_clamped = (in_nslices_i == '0 || in_nslices_i > NumSlicesC) ? NumSlicesC : in_nslices_i;
  assign is_final  = ({1'b0, idx_q} == (n_q - CntOne));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    n_d         = n_q;
    last_d      = last_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    load        = 1'b0;

    case (state_q)
      SerIdle: in_ready_o = 1'b1;
      SerSend: begin
        out_valid_o = 1'b1;
        // Ready only on the final slice so the next word lands with no bubble.
        in_ready_o  = is_final & out_ready_i;
        if (out_ready_i) begin
          if (!is_final) idx_d = idx_q + IdxOne;
          else           state_d = SerIdle;
        end
      end
      default: state_d = SerIdle;
    endcase

    load = in_valid_i & in_ready_o;
    if (load) begin
      state_d = SerSend;
      data_d  = in_data_i;
      n_d     = n_clamped;
      last_d  = in_last_i;
      idx_d   = '0;
    end

`ifdef ABR_SLICE_SER_ZEROIZE_EN
    if (zeroize_i) begin
      state_d    = SerIdle;
      data_d     = '0;
      idx_d      = '0;
      n_d        = '0;
      last_d     = 1'b0;
      in_ready_o = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SerIdle;
      data_q  <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      last_q  <= last_d;
    end
  end

  abr_prim_slicer #(
    .InW   (InW),
    .OutW  (OutW),
    .IndexW(IndexW)
  ) u_slicer (
    .sel_i (idx_q),
    .data_i(data_q),
    .data_o(out_data_o)
  );

  assign out_last_o = last_q & is_final & out_valid_o;
  assign busy_o     = (state_q == SerSend);

endmodule
